// File: rtl/siacore_pkg.sv
// Shared constants and helpers for the Sia BLAKE2b-256 search lane.
package siacore_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned NWORDS  = 16;
  localparam int unsigned STATE_W = WORD_W * NWORDS;
  localparam int unsigned WORK_W  = 640;
  localparam int unsigned NONCE_W = 32;
  localparam int unsigned HDR_LEN = 80;
  localparam int unsigned NROUNDS = 12;

  // Digest length 32, fanout 1, depth 1, no key.
  localparam logic [63:0] PARAM_WORD = 64'h0000_0000_0101_0020;

  localparam logic [63:0] IV [0:7] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [3:0] SIGMA [0:9][0:15] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,  4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd14, 4'd10, 4'd4,  4'd8,  4'd9,  4'd15, 4'd13, 4'd6,  4'd1,  4'd12, 4'd0,  4'd2,  4'd11, 4'd7,  4'd5,  4'd3},
    '{4'd11, 4'd8,  4'd12, 4'd0,  4'd5,  4'd2,  4'd15, 4'd13, 4'd10, 4'd14, 4'd3,  4'd6,  4'd7,  4'd1,  4'd9,  4'd4},
    '{4'd7,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd11, 4'd14, 4'd2,  4'd6,  4'd5,  4'd10, 4'd4,  4'd0,  4'd15, 4'd8},
    '{4'd9,  4'd0,  4'd5,  4'd7,  4'd2,  4'd4,  4'd10, 4'd15, 4'd14, 4'd1,  4'd11, 4'd12, 4'd6,  4'd8,  4'd3,  4'd13},
    '{4'd2,  4'd12, 4'd6,  4'd10, 4'd0,  4'd11, 4'd8,  4'd3,  4'd4,  4'd13, 4'd7,  4'd5,  4'd15, 4'd14, 4'd1,  4'd9},
    '{4'd12, 4'd5,  4'd1,  4'd15, 4'd14, 4'd13, 4'd4,  4'd10, 4'd0,  4'd7,  4'd6,  4'd3,  4'd9,  4'd2,  4'd8,  4'd11},
    '{4'd13, 4'd11, 4'd7,  4'd14, 4'd12, 4'd1,  4'd3,  4'd9,  4'd5,  4'd0,  4'd15, 4'd4,  4'd8,  4'd6,  4'd2,  4'd10},
    '{4'd6,  4'd15, 4'd14, 4'd9,  4'd11, 4'd3,  4'd0,  4'd8,  4'd12, 4'd2,  4'd13, 4'd7,  4'd1,  4'd4,  4'd10, 4'd5},
    '{4'd10, 4'd2,  4'd8,  4'd4,  4'd7,  4'd6,  4'd1,  4'd5,  4'd15, 4'd11, 4'd9,  4'd14, 4'd3,  4'd12, 4'd13, 4'd0}
  };

  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 8; i++) y[8*i +: 8] = x[8*(7-i) +: 8];
    return y;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Starting working vector: header length is fixed and this is the final block,
  // so the initial state is the same for every attempt.
  function automatic logic [STATE_W-1:0] init_state();
    logic [STATE_W-1:0] s;
    for (int i = 0; i < 8; i++) begin
      s[64*i +: 64]     = IV[i];
      s[64*(i+8) +: 64] = IV[i];
    end
    s[63:0]             = IV[0] ^ PARAM_WORD;
    s[64*12 +: 64]      = IV[4] ^ 64'(HDR_LEN);
    s[64*14 +: 64]      = ~IV[6];
    return s;
  endfunction

endpackage

// File: rtl/siacore_round.sv
// One full BLAKE2b round (4 column G + 4 diagonal G), purely combinational.
module blake2b_round
  import siacore_pkg::*;
(
  input  logic [1023:0] state_in,
  input  logic [1023:0] msg,
  input  logic [3:0]    round,
  output logic [1023:0] state_out_c
);

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Mixing function; returns {a, b, c, d}.
  function automatic logic [255:0] g(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, input logic [63:0] d,
                                     input logic [63:0] x, input logic [63:0] y);
    logic [63:0] a1, b1, c1, d1;
    a1 = a + b + x;
    d1 = rotr(d ^ a1, 32);
    c1 = c + d1;
    b1 = rotr(b ^ c1, 24);
    a1 = a1 + b1 + y;
    d1 = rotr(d1 ^ a1, 16);
    c1 = c1 + d1;
    b1 = rotr(b1 ^ c1, 63);
    return {a1, b1, c1, d1};
  endfunction

  logic [63:0]  v [0:15];
  logic [63:0]  m [0:15];
  logic [3:0]   row;
  logic [255:0] gout;

  // Unpack, apply column then diagonal steps, repack.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      v[i] = state_in[64*i +: 64];
      m[i] = msg[64*i +: 64];
    end
    gout = '0;
    row  = (round >= 4'd10) ? round - 4'd10 : round;
    for (int i = 0; i < 4; i++) begin
      gout = g(v[i], v[i+4], v[i+8], v[i+12],
               m[SIGMA[row][2*i]], m[SIGMA[row][2*i+1]]);
      {v[i], v[i+4], v[i+8], v[i+12]} = gout;
    end
    for (int i = 0; i < 4; i++) begin
      gout = g(v[i], v[4 + ((i+1) % 4)], v[8 + ((i+2) % 4)], v[12 + ((i+3) % 4)],
               m[SIGMA[row][8+2*i]], m[SIGMA[row][9+2*i]]);
      {v[i], v[4 + ((i+1) % 4)], v[8 + ((i+2) % 4)], v[12 + ((i+3) % 4)]} = gout;
    end
    for (int i = 0; i < 16; i++) state_out_c[64*i +: 64] = v[i];
  end

endmodule

// File: rtl/siacore.sv
// Sia proof-of-work lane: iterates the header nonce until BLAKE2b-256 meets target.
module siacore
  import siacore_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [639:0] work,
  input  logic [63:0]  target,
  input  logic         valid,
  output logic         busy,
  output logic         found,
  output logic [31:0]  nonce
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic [1:0]    fsm_q,     fsm_d;
  logic [3:0]    r_q,       r_d;
  logic [31:0]   v_q,       v_d;
  logic [351:0]  work_hi_q, work_hi_d;
  logic [255:0]  work_lo_q, work_lo_d;
  logic [63:0]   target_q,  target_d;
  logic [1023:0] state_q,   state_d;
  logic          busy_d, found_d;
  logic [31:0]   nonce_d;

  logic [1023:0] msg_c;
  logic [1023:0] round_out_c;
  logic [63:0]   out0_c;
  logic          hit_c;

  // Header words with the live nonce spliced in; words 10..15 are zero padding.
  assign msg_c  = {384'b0, work_hi_q, v_q, work_lo_q};
  assign out0_c = IV[0] ^ PARAM_WORD ^ state_q[63:0] ^ state_q[575:512];
  assign hit_c  = bswap64(out0_c) <= target_q;

  blake2b_round u_round (
    .state_in    (state_q),
    .msg         (msg_c),
    .round       (r_q),
    .state_out_c (round_out_c)
  );

  // State register for FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      r_q       <= '0;
      v_q       <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      target_q  <= '0;
      state_q   <= '0;
      busy      <= 1'b0;
      found     <= 1'b0;
      nonce     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      r_q       <= r_d;
      v_q       <= v_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      target_q  <= target_d;
      state_q   <= state_d;
      busy      <= busy_d;
      found     <= found_d;
      nonce     <= nonce_d;
    end
  end

  // Next-state logic; a new valid always restarts the search from load.
  always_comb begin
    fsm_d     = fsm_q;
    r_d       = r_q;
    v_d       = v_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    target_d  = target_q;
    state_d   = state_q;
    busy_d    = busy;
    found_d   = 1'b0;
    nonce_d   = nonce;

    if (valid) begin
      work_hi_d = work[639:288];
      work_lo_d = work[255:0];
      v_d       = work[287:256];
      target_d  = target;
      state_d   = init_state();
      r_d       = '0;
      fsm_d     = S_ROUND;
      busy_d    = 1'b1;
    end else begin
      case (fsm_q)
        S_ROUND: begin
          state_d = round_out_c;
          if (r_q == 4'(NROUNDS - 1)) fsm_d = S_CHECK;
          else                        r_d   = r_q + 4'd1;
        end
        S_CHECK: begin
          if (hit_c) begin
            found_d = 1'b1;
            nonce_d = bswap32(v_q);
            busy_d  = 1'b0;
            fsm_d   = S_IDLE;
          end else begin
            v_d     = v_q + 32'd1;
            state_d = init_state();
            r_d     = '0;
            fsm_d   = S_ROUND;
          end
        end
        S_IDLE:  fsm_d = S_IDLE;
        default: fsm_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_siacore.sv
// Self-checking bench for siacore against a software BLAKE2b-256 reference.
module tb_siacore;

  logic         clk;
  logic         rst;
  logic [639:0] work;
  logic [63:0]  target;
  logic         valid;
  logic         busy;
  logic         found;
  logic [31:0]  nonce;

  int checks = 0;
  int errors = 0;

  siacore dut (
    .clk    (clk),
    .rst    (rst),
    .work   (work),
    .target (target),
    .valid  (valid),
    .busy   (busy),
    .found  (found),
    .nonce  (nonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] B2_IV [0:7] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam int SIG [0:9][0:15] = '{
    '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15},
    '{14,10,4,8,9,15,13,6,1,12,0,2,11,7,5,3},
    '{11,8,12,0,5,2,15,13,10,14,3,6,7,1,9,4},
    '{7,9,3,1,13,12,11,14,2,6,5,10,4,0,15,8},
    '{9,0,5,7,2,4,10,15,14,1,11,12,6,8,3,13},
    '{2,12,6,10,0,11,8,3,4,13,7,5,15,14,1,9},
    '{12,5,1,15,14,13,4,10,0,7,6,3,9,2,8,11},
    '{13,11,7,14,12,1,3,9,5,0,15,4,8,6,2,10},
    '{6,15,14,9,11,3,0,8,12,2,13,7,1,4,10,5},
    '{10,2,8,4,7,6,1,5,15,11,9,14,3,12,13,0}
  };

  localparam int GIDX [0:7][0:3] = '{
    '{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}
  };

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // BLAKE2b-256 of the 80 header bytes; returns hash bytes 0..7 as a big-endian value.
  function automatic logic [63:0] ref_hash(input logic [639:0] w);
    logic [7:0]  hdr [0:79];
    logic [63:0] m [0:15];
    logic [63:0] v [0:15];
    logic [63:0] h0, outw, res;
    int a, b, c, d, s;
    for (int i = 0; i < 80; i++) hdr[i] = w[8*i +: 8];
    for (int j = 0; j < 16; j++) begin
      m[j] = 64'd0;
      if (j < 10)
        for (int k = 0; k < 8; k++) m[j] = m[j] | (64'(hdr[8*j+k]) << (8*k));
    end
    h0 = B2_IV[0] ^ 64'h01010020;
    v[0] = h0;
    for (int i = 1; i < 8; i++) v[i] = B2_IV[i];
    for (int i = 0; i < 8; i++) v[8+i] = B2_IV[i];
    v[12] = v[12] ^ 64'd80;
    v[14] = ~v[14];
    for (int r = 0; r < 12; r++) begin
      s = r % 10;
      for (int gi = 0; gi < 8; gi++) begin
        a = GIDX[gi][0]; b = GIDX[gi][1]; c = GIDX[gi][2]; d = GIDX[gi][3];
        v[a] = v[a] + v[b] + m[SIG[s][2*gi]];
        v[d] = ror(v[d] ^ v[a], 32);
        v[c] = v[c] + v[d];
        v[b] = ror(v[b] ^ v[c], 24);
        v[a] = v[a] + v[b] + m[SIG[s][2*gi+1]];
        v[d] = ror(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = ror(v[b] ^ v[c], 63);
      end
    end
    outw = h0 ^ v[0] ^ v[8];
    res = 64'd0;
    for (int bi = 0; bi < 8; bi++) res = {res[55:0], outw[8*bi +: 8]};
    return res;
  endfunction

  function automatic logic [639:0] rand_work();
    logic [639:0] w;
    for (int i = 0; i < 20; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] f);
    logic [31:0] y;
    for (int i = 0; i < 4; i++) y[8*i +: 8] = f[8*(3-i) +: 8];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First attempt (0-based) whose hash meets target, scanning wrapping nonce values.
  task automatic expect_hit(input logic [639:0] w, input logic [63:0] t, input int max_att,
                            output int exp_cyc, output logic [31:0] exp_nonce);
    logic [639:0] wa;
    logic [31:0]  f;
    exp_cyc   = 0;
    exp_nonce = 32'd0;
    wa        = w;
    for (int k = 0; k < max_att; k++) begin
      f = w[287:256] + 32'(k);
      wa[287:256] = f;
      if (ref_hash(wa) <= t) begin
        exp_cyc   = 13 * (k + 1);
        exp_nonce = swap32(f);
        break;
      end
    end
  endtask

  // Pulse valid and watch for found; exp_cyc = 0 means no found within limit.
  task automatic run_search(input string tag, input logic [639:0] w, input logic [63:0] t,
                            input int exp_cyc, input logic [31:0] exp_nonce, input int limit);
    int got, busy_cnt;
    @(negedge clk);
    work = w; target = t; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    got = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (found === 1'b1) begin
        got = n;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    if (exp_cyc > 0) begin
      chk({tag, "_latency"}, 64'(got), 64'(exp_cyc));
      chk({tag, "_nonce"}, 64'(nonce), 64'(exp_nonce));
      chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_cyc));
      chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    end else begin
      chk({tag, "_no_found"}, 64'(got), 64'd0);
    end
  endtask

  logic [639:0] w, w2;
  logic [63:0]  t, h;
  int           ec;
  logic [31:0]  en;
  int           early;

  initial begin
    rst = 1'b1; valid = 1'b0; work = '0; target = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_found", 64'(found), 64'd0);
    chk("reset_nonce", 64'(nonce), 64'd0);
    rst = 1'b0;

    // All-ones target hits on attempt 0 with the byte-swapped field.
    w = rand_work();
    w[287:256] = 32'h78563412;
    run_search("ones", w, 64'hFFFF_FFFF_FFFF_FFFF, 13, 32'h12345678, 40);

    // Model-derived targets that land on attempt k (or earlier if an earlier hash is smaller).
    for (int i = 0; i < 10; i++) begin
      w  = rand_work();
      w2 = w;
      w2[287:256] = w[287:256] + 32'(i);
      t = ref_hash(w2);
      expect_hit(w, t, i + 1, ec, en);
      run_search($sformatf("vec%0d", i), w, t, ec, en, 13 * (i + 1) + 20);
    end

    // Nonce wrap: target taken from the field value 0 reached via FFFFFFFE, FFFFFFFF.
    w  = rand_work();
    w[287:256] = 32'hFFFF_FFFE;
    w2 = w;
    w2[287:256] = 32'h0000_0000;
    t = ref_hash(w2);
    expect_hit(w, t, 3, ec, en);
    run_search("wrap", w, t, ec, en, 60);

    // Exact hash boundary: H hits on attempt 0, H-1 does not.
    w = rand_work();
    h = ref_hash(w);
    run_search("hash_eq", w, h, 13, swap32(w[287:256]), 30);
    if (h != 64'd0) run_search("hash_lt", w, h - 64'd1, 0, 32'd0, 13);

    // Zero target: search keeps running across the wrap with no found.
    w = rand_work();
    w[287:256] = 32'hFFFF_FFFE;
    run_search("zero_tgt", w, 64'd0, 0, 32'd0, 1000);
    chk("zero_tgt_busy", 64'(busy), 64'd1);

    // Reset five cycles into a search aborts it.
    w = rand_work();
    @(negedge clk);
    work = w; target = 64'hFFFF_FFFF_FFFF_FFFF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_found", 64'(found), 64'd0);
    chk("midrst_nonce", 64'(nonce), 64'd0);
    rst = 1'b0;
    w[287:256] = 32'hA1B2C3D4;
    run_search("after_rst", w, 64'hFFFF_FFFF_FFFF_FFFF, 13, 32'hD4C3B2A1, 40);

    // Re-pulsed valid abandons the first job.
    w = rand_work();
    @(negedge clk);
    work = w; target = 64'hFFFF_FFFF_FFFF_FFFF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    early = 0;
    repeat (4) begin
      @(negedge clk);
      if (found === 1'b1) early++;
    end
    chk("revalid_early", 64'(early), 64'd0);
    w2 = rand_work();
    run_search("revalid", w2, 64'hFFFF_FFFF_FFFF_FFFF, 13, swap32(w2[287:256]), 40);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
